conv_sched: RTL and testbench

- Round-robin scheduler that shares one combinational 4-bit code-converter instance between NUM_REQ requesters.
- Accepts one code per grant and drives it onto the converter input, holding it stable for CONV_LAT cycles.
- Samples the converter output and returns the result, tagged with the requester ID, through a valid/ready result port.
- Flags codes outside the converter's legal input set and counts them.

---
 rtl/conv_sched.sv | 178 +++++++++++++++++
 tb/tb_conv_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// conv_sched: round-robin scheduler that shares one external combinational
// 4-bit code converter between NUM_REQ requesters.
//
// A code is accepted from the granted requester, driven on conv_in and held
// for CONV_LAT cycles. conv_out is then sampled and returned on a
// valid/ready result port, tagged with the requester index. Codes outside
// the converter's legal input set are flagged and counted.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is a one-hot grant
//   req_code          packed per-requester codes, requester i at [4i+3:4i]
//   conv_in/conv_out  registered code to converter / converter result
//   res_valid/ready   result handshake
//   res_code/id/err   converted code (0 when illegal), owner, illegal flag
//   err_count         saturating count of illegal codes
//   busy              high whenever the scheduler is not idle
module conv_sched #(
    parameter int NUM_REQ  = 4,
    parameter int IDW      = 2,
    parameter int CONV_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_code,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [3:0]             conv_in,
    input  logic [3:0]             conv_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [3:0]             res_code,
    output logic [IDW-1:0]         res_id,
    output logic                   res_err,
    output logic [7:0]             err_count,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    state_t         state, state_d;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] grant;
    logic           any_valid;
    logic           legal_q;
    logic [3:0]     cnt;
    logic [3:0]     sel_code;
    int unsigned    cand;

    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
            4'b0111, 4'b1001, 4'b1011, 4'b1100, 4'b1101: is_legal = 1'b1;
            default:                                      is_legal = 1'b0;
        endcase
    endfunction

    // Search from ptr upward with wrap; the inner compare against a constant
    // index keeps every select on req_valid static.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!any_valid && (cand == j) && req_valid[j]) begin
                    any_valid = 1'b1;
                    grant     = IDW'(j);
                end
            end
        end
    end

    always_comb begin
        sel_code  = '0;
        req_ready = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (grant == IDW'(j)) begin
                sel_code = req_code[4*j +: 4];
            end
        end
        // rst gating keeps the grant low while reset is asserted.
        if ((state == IDLE) && any_valid && !rst) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (grant == IDW'(j)) begin
                    req_ready[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (32'(grant) == 32'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant + IDW'(1);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (any_valid)  state_d = CONV;
            CONV:    if (cnt == '0)  state_d = HOLD;
            HOLD:    if (res_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            gnt_id    <= '0;
            legal_q   <= 1'b0;
            cnt       <= '0;
            conv_in   <= '0;
            res_valid <= 1'b0;
            res_code  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        conv_in <= sel_code;
                        gnt_id  <= grant;
                        legal_q <= is_legal(sel_code);
                        ptr     <= ptr_next;
                        cnt     <= 4'(CONV_LAT - 1);
                    end
                end
                CONV: begin
                    if (cnt == '0) begin
                        res_code  <= legal_q ? conv_out : 4'b0000;
                        res_id    <= gnt_id;
                        res_err   <= !legal_q;
                        res_valid <= 1'b1;
                        if (!legal_q && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: stimulus pushes expected grants and
// results into queues, negedge monitors pop and compare. A second instance
// with CONV_LAT=3 exercises error-counter saturation.
module tb_conv_sched;

    typedef struct {
        logic [1:0] id;
        logic [3:0] code;
        logic       err;
        logic [7:0] ec;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_code;
    logic [3:0]  req_ready;
    logic [3:0]  conv_in;
    logic [3:0]  conv_out;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_code;
    logic [1:0]  res_id;
    logic        res_err;
    logic [7:0]  err_count;
    logic        busy;

    logic        s_rst;
    logic [3:0]  s_valid;
    logic [15:0] s_code;
    logic [3:0]  s_rr;
    logic [3:0]  s_conv_in;
    logic [3:0]  s_conv_out;
    logic        s_res_valid;
    logic        s_ready;
    logic [3:0]  s_res_code;
    logic [1:0]  s_res_id;
    logic        s_res_err;
    logic [7:0]  s_err_count;
    logic        s_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    exp_t exp_q[$];
    int   gnt_q[$];
    int   gnt_seen = 0;
    int   last_gnt_cyc = 0;
    int   last_acc_cyc = 0;
    bit   gnt_prev_ok = 0;
    bit   spacing_en = 0;
    logic [3:0] prev_rr = '0;
    logic rv_q = 1'b0;

    int   s_results = 0;
    int   s_gcyc = 0;
    logic [3:0] s_gcode = '0;
    logic s_rv_q = 1'b0;

    // Golden converter, hand-tabulated; illegal inputs give a nonzero value
    // so that the zeroing of res_code is observable.
    function automatic logic [3:0] conv_f(input logic [3:0] c);
        case (c)
            4'b0000: conv_f = 4'hA;
            4'b0001: conv_f = 4'h5;
            4'b0011: conv_f = 4'h0;
            4'b0100: conv_f = 4'hC;
            4'b0101: conv_f = 4'h3;
            4'b0111: conv_f = 4'h9;
            4'b1001: conv_f = 4'h6;
            4'b1011: conv_f = 4'hF;
            4'b1100: conv_f = 4'h1;
            4'b1101: conv_f = 4'h8;
            default: conv_f = 4'hE;
        endcase
    endfunction

    logic [3:0] legal_codes [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
                                     4'b0111, 4'b1001, 4'b1011, 4'b1100, 4'b1101};
    logic [3:0] legal_exp   [10] = '{4'hA, 4'h5, 4'h0, 4'hC, 4'h3,
                                     4'h9, 4'h6, 4'hF, 4'h1, 4'h8};
    logic [3:0] bad_codes   [6]  = '{4'b0010, 4'b0110, 4'b1000, 4'b1010, 4'b1110, 4'b1111};

    assign conv_out   = conv_f(conv_in);
    assign s_conv_out = conv_f(s_conv_in);

    conv_sched #(.NUM_REQ(4), .IDW(2), .CONV_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
        .req_ready(req_ready), .conv_in(conv_in), .conv_out(conv_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
        .res_id(res_id), .res_err(res_err), .err_count(err_count), .busy(busy)
    );

    conv_sched #(.NUM_REQ(4), .IDW(2), .CONV_LAT(3)) dut_s (
        .clk(clk), .rst(s_rst), .req_valid(s_valid), .req_code(s_code),
        .req_ready(s_rr), .conv_in(s_conv_in), .conv_out(s_conv_out),
        .res_valid(s_res_valid), .res_ready(s_ready), .res_code(s_res_code),
        .res_id(s_res_id), .res_err(s_res_err), .err_count(s_err_count), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [3:0] code,
                            input logic err, input logic [7:0] ec);
        exp_t e;
        e.id = id; e.code = code; e.err = err; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic wait_gnt(input int n);
        int tgt;
        int t;
        tgt = gnt_seen + n;
        t = 0;
        while (gnt_seen < tgt && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        tests++;
        if (gnt_seen < tgt) begin
            fails++;
            $display("FAIL wait_gnt: grants seen %0d, expected %0d", gnt_seen, tgt);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_idle", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gnt_prev_ok = 0;
    endtask

    // Grant and result monitor for the CONV_LAT=1 instance.
    always @(negedge clk) begin
        int gi;
        exp_t e;
        if (req_ready != '0) begin
            chk("gnt_onehot", 32'($onehot(req_ready)), 1);
            chk("gnt_one_cycle", prev_rr, 0);
            gi = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
            if (gnt_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL gnt_unexpected: got grant %0d, expected none", gi);
            end else begin
                chk("gnt_order", gi, gnt_q.pop_front());
            end
            if (spacing_en && gnt_prev_ok) chk("gnt_spacing", cyc - last_gnt_cyc, 3);
            last_gnt_cyc = cyc;
            gnt_prev_ok = 1;
            gnt_seen++;
        end
        prev_rr = req_ready;

        if (res_valid && !rv_q) chk("res_latency", cyc - last_gnt_cyc, 2);
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL res_unexpected: got id %0d code %0h, expected none", res_id, res_code);
            end else begin
                e = exp_q.pop_front();
                chk("res_id", res_id, e.id);
                chk("res_code", res_code, e.code);
                chk("res_err", res_err, e.err);
                chk("err_count", err_count, e.ec);
            end
            last_acc_cyc = cyc;
        end
        rv_q = res_valid;
    end

    // Monitor for the CONV_LAT=3 saturation instance.
    always @(negedge clk) begin
        int exp_ec;
        if (s_rr != '0) begin
            s_gcode = s_code[3:0];
            s_gcyc = cyc;
        end
        if (s_busy && !s_res_valid) chk("sat_conv_in_stable", s_conv_in, s_gcode);
        if (s_res_valid && !s_rv_q) chk("sat_latency", cyc - s_gcyc, 4);
        if (s_res_valid && s_ready) begin
            s_results++;
            exp_ec = (s_results > 255) ? 255 : s_results;
            chk("sat_err_count", s_err_count, exp_ec);
            chk("sat_res_err", s_res_err, 1);
            chk("sat_res_code", s_res_code, 0);
        end
        s_rv_q = s_res_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b0; s_rst = 1'b0;
        req_valid = '0; req_code = '0; res_ready = 1'b1;
        s_valid = '0; s_code = '0; s_ready = 1'b1;
        #1;
        rst = 1'b1; s_rst = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_conv_in", conv_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_code", res_code, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Legal codes from requester 0.
        spacing_en = 1;
        for (int i = 0; i < 10; i++) begin
            req_code[3:0] = legal_codes[i];
            req_valid = 4'b0001;
            gnt_q.push_back(0);
            push_exp(2'd0, legal_exp[i], 1'b0, 8'd0);
            wait_gnt(1);
        end
        req_valid = '0;
        drain();

        // Round-robin with all requesters valid.
        do_reset();
        req_code = {4'b0101, 4'b0100, 4'b0011, 4'b0001};
        req_valid = 4'hF;
        gnt_q.push_back(0); push_exp(2'd0, 4'h5, 1'b0, 8'd0);
        gnt_q.push_back(1); push_exp(2'd1, 4'h0, 1'b0, 8'd0);
        gnt_q.push_back(2); push_exp(2'd2, 4'hC, 1'b0, 8'd0);
        gnt_q.push_back(3); push_exp(2'd3, 4'h3, 1'b0, 8'd0);
        gnt_q.push_back(0); push_exp(2'd0, 4'h5, 1'b0, 8'd0);
        wait_gnt(5);
        req_valid = '0;
        drain();
        spacing_en = 0;

        // Illegal codes from requester 2.
        do_reset();
        req_code = '0;
        req_code[11:8] = 4'b0010;
        req_valid = 4'b0100;
        gnt_q.push_back(2); push_exp(2'd2, 4'h0, 1'b1, 8'd1);
        wait_gnt(1);
        req_code[11:8] = 4'b1111;
        gnt_q.push_back(2); push_exp(2'd2, 4'h0, 1'b1, 8'd2);
        wait_gnt(1);
        req_code[11:8] = 4'b0111;
        gnt_q.push_back(2); push_exp(2'd2, 4'h9, 1'b0, 8'd2);
        wait_gnt(1);
        req_valid = '0;
        drain();

        // Asynchronous reset in the middle of CONV.
        req_code[11:8] = 4'b0011;
        req_valid = 4'b0100;
        gnt_q.push_back(2);
        wait_gnt(1);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_conv_in", conv_in, 4'b0011);
        #1;
        rst = 1'b1;
        req_valid = 4'b1010;
        req_code[7:4] = 4'b0101;
        req_code[15:12] = 4'b1100;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_conv_in", conv_in, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_code", res_code, 0);
        chk("arst_res_id", res_id, 0);
        chk("arst_res_err", res_err, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gnt_prev_ok = 0;
        gnt_q.push_back(1); push_exp(2'd1, 4'h3, 1'b0, 8'd0);
        wait_gnt(1);
        req_valid = '0;
        drain();

        // Backpressure on the result port.
        res_ready = 1'b0;
        req_code[3:0] = 4'b0100;
        req_code[7:4] = 4'b1001;
        req_valid = 4'b0011;
        gnt_q.push_back(0); push_exp(2'd0, 4'hC, 1'b0, 8'd0);
        gnt_q.push_back(1); push_exp(2'd1, 4'h6, 1'b0, 8'd0);
        wait_gnt(1);
        req_valid = 4'b0010;
        t = 0;
        while (!res_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_res_valid_rise", res_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_code", res_code, 4'hC);
            chk("bp_hold_id", res_id, 0);
            chk("bp_no_grant", req_ready, 0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_gnt(1);
        chk("bp_next_grant_cycle", last_gnt_cyc, last_acc_cyc + 1);
        req_valid = '0;
        drain();

        // Saturation on the CONV_LAT=3 instance.
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        s_valid = 4'b0001;
        t = 0;
        while (s_results < 260 && t < 3000) begin
            s_code[3:0] = bad_codes[t % 6];
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = '0;
        chk("sat_results", s_results, 260);
        repeat (6) @(posedge clk);
        #1;
        chk("sat_final_count", s_err_count, 8'hFF);
        chk("sat_idle", s_busy, 0);

        chk("gnt_queue_empty", gnt_q.size(), 0);
        chk("res_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
